soc_design_dma_0_read_aligner: RTL and testbench
================================================

# soc_design_dma_0_read_aligner

Read-side counterpart of the DMA write byte-enable logic. It sits between the DMA read master's Avalon-MM read port and the DMA data FIFO. For each issued read it records the address offset and transfer size. When the read data returns, it extracts the addressed byte or halfword lane, aligns it to lane 0, and buffers it for the write side behind a valid/ready handshake. Because Avalon `readdatavalid` cannot be back-pressured, the block also provides credit-based issue throttling.

## Interface
Parameters:
- `DEPTH`, 4: entries in the offset queue and the data queue, and the maximum reads in flight plus buffered; must be a power of 2, ≥2.
- `ADDR_W`, 11: read address width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `byte_access` in 1: byte transfer size; the size inputs are one-hot.
- `hw` in 1: halfword transfer size.
- `word` in 1: word transfer size.
- `read_issue` in 1: the read master issues a read this cycle (`read` asserted and not wait-requested).
- `read_address` in ADDR_W: address of the issued read; sampled with `read_issue`.
- `readdatavalid` in 1: Avalon read data valid.
- `readdata` in 32: Avalon read data.
- `can_issue` out 1: the read master may issue a read this cycle.
- `out_valid` out 1: the head entry of the data queue is valid.
- `out_ready` in 1: the consumer accepts the head entry.
- `out_data` out 32: aligned data.
- `proto_err` out 1: sticky protocol-error flag.

## Operation
- On `read_issue && can_issue`, push {`read_address[1:0]`, size} into the offset queue and increment `outstanding`.
- On `readdatavalid`, pop the offset queue and decrement `outstanding`, then align the data and push it into the data queue:
  - byte: lane = offset[1:0]; the selected byte goes to `out_data[7:0]`.
  - hw: lane = offset[1]; `readdata[31:16]` or `readdata[15:0]` goes to `out_data[15:0]`.
  - word: `readdata` passes through unchanged.
  - Upper bits follow the `DMA_READ_REPLICATE_EN` setting (see Configuration).
- `can_issue` = (`outstanding` + `data_count`) < DEPTH, computed combinationally from registered counts.
- A data queue pop occurs on `out_valid && out_ready`.
- Same-cycle issue, return and pop are all legal. Each counter updates by its net change (+1, 0 or −1); no event is lost.
- Size is captured per read, so a change to `byte_access`/`hw`/`word` between issue and return does not affect data already in flight.
- Error cases set `proto_err`; it is cleared only by reset:
  - `read_issue` while `can_issue` = 0: the issue is ignored and no queue entry is created.
  - `readdatavalid` while `outstanding` = 0: the data is dropped and no push occurs.
  - A size field that is not one-hot at issue: the entry is treated as word.
- Queue pointers are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `can_issue` = 1, `proto_err` = 0. All pointers and counts are 0.
- Reset asserted mid-operation discards all in-flight and buffered entries immediately. Returns arriving after reset deasserts with `outstanding` = 0 set `proto_err`.
- Latency: `readdatavalid` at cycle N → `out_valid` = 1 with aligned data at N+1, when the data queue was empty.
- `out_data` is stable while `out_valid && !out_ready`.
- When the queue is full, a pop in cycle N raises `can_issue` in N+1.
- Throughput is one read per cycle sustained when `out_ready` = 1.

## Configuration
- `DMA_READ_REPLICATE_EN` defined: byte results are replicated to all 4 lanes, as {4{b}}. Halfword results are replicated to both halves, as {2{h}}.
- `DMA_READ_REPLICATE_EN` undefined: byte and halfword results are zero-extended.
- Word transfers are identical in both builds.

## Test plan
- Byte issue at addresses 0x101, 0x102, 0x103, 0x100; `readdata` = 0xA1B2C3D4 each time; `out_ready` = 1 → `out_data` = 0x000000C3, 0x000000B2, 0x000000A1, 0x000000D4. With the macro defined: 0xC3C3C3C3, 0xB2B2B2B2, 0xA1A1A1A1, 0xD4D4D4D4.
- hw issue at 0x002 then 0x000 with data 0x12345678 → 0x00001234, then 0x00005678. Word issue at 0x004 → 0x12345678.
- DEPTH = 4, `out_ready` = 0, issue 4 reads → `can_issue` = 0 after the 4th. A 5th `read_issue` sets `proto_err` and creates no entry. Raise `out_ready` for one pop → `can_issue` = 1 the next cycle.
- Issue byte@0x1, switch the size to word, issue @0x4, then return both → the first output is byte-aligned and the second is word. Per-read capture is honoured.
- Simultaneous `read_issue`, `readdatavalid` and pop for 20 cycles → counts stay constant, with no loss or duplication of data, in order.
- `readdatavalid` with nothing outstanding → `proto_err` = 1 and `out_valid` stays 0. Assert `reset` with 3 entries buffered → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/soc_design_dma_0_read_aligner.sv
// ---------------------------------------------------------------------------
// soc_design_dma_0_read_aligner
//
// Read-side lane aligner for the DMA engine. Every read accepted from the
// read master records its address offset and transfer size in an offset
// queue. When Avalon read data returns, the oldest record is popped. The
// addressed byte or halfword is moved down to lane 0, and the result is
// buffered in a data queue. A valid/ready handshake drains that queue.
//
// readdatavalid cannot be back-pressured. For that reason can_issue only
// allows a new read while (reads in flight + buffered results) < DEPTH. This
// guarantees that a returning word always has room in the data queue.
//
// Build option:
//   DMA_READ_REPLICATE_EN  defined   : byte results are replicated to all
//                                      four lanes, and halfword results to
//                                      both halves.
//                          undefined : byte and halfword results are
//                                      zero-extended.
//
// Parameters:
//   DEPTH   entries per queue / max reads in flight plus buffered (pow2, >=2)
//   ADDR_W  read address width (>= 2)
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   byte_access     byte transfer size      (size inputs are one-hot)
//   hw              halfword transfer size
//   word            word transfer size
//   read_issue      read master issues a read this cycle
//   read_address    address of the issued read
//   readdatavalid   Avalon read data valid
//   readdata        Avalon read data
//   can_issue       read master may issue a read this cycle
//   out_valid       head of the data queue is valid
//   out_ready       consumer accepts the head entry
//   out_data        aligned data
//   proto_err       sticky protocol-error flag
// ---------------------------------------------------------------------------
module soc_design_dma_0_read_aligner #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_access,
    input  logic              hw,
    input  logic              word,
    input  logic              read_issue,
    input  logic [ADDR_W-1:0] read_address,
    input  logic              readdatavalid,
    input  logic [31:0]       readdata,
    output logic              can_issue,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic [1:0] offset;
        size_e      size;
    } offEntry_t;

    offEntry_t   offMem_q  [DEPTH];
    logic [31:0] dataMem_q [DEPTH];

    logic [PTR_W-1:0] offWrPtr_q,  offWrPtr_d;
    logic [PTR_W-1:0] offRdPtr_q,  offRdPtr_d;
    logic [PTR_W-1:0] dataWrPtr_q, dataWrPtr_d;
    logic [PTR_W-1:0] dataRdPtr_q, dataRdPtr_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] dataCount_q,   dataCount_d;
    logic             protoErr_q,    protoErr_d;

    logic      issueAccept;
    logic      retAccept;
    logic      popAccept;
    size_e     issueSize;
    offEntry_t headEntry;
    logic [31:0] alignedData;
    logic [CNT_W:0] inFlightTotal;

    // Only the low two address bits select a lane.
    logic unusedAddrBits;
    assign unusedAddrBits = ^read_address[ADDR_W-1:2];

    // Moves the addressed lane down to bit 0 and fills the upper bits
    // according to the build option.
    function automatic logic [31:0] alignData(input logic [31:0] d,
                                              input logic [1:0]  off,
                                              input size_e       sz);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (sz)
`ifdef DMA_READ_REPLICATE_EN
            SIZE_BYTE: alignData = {4{b}};
            SIZE_HALF: alignData = {2{h}};
`else
            SIZE_BYTE: alignData = {24'h0, b};
            SIZE_HALF: alignData = {16'h0, h};
`endif
            default:   alignData = d;
        endcase
    endfunction

    // Handshake qualification. can_issue comes only from registered counts,
    // so it never depends combinationally on this cycle's return or pop.
    always_comb begin
        inFlightTotal = {1'b0, outstanding_q} + {1'b0, dataCount_q};
        can_issue     = inFlightTotal < (CNT_W + 1)'(DEPTH);
        out_valid     = dataCount_q != '0;
        issueAccept   = read_issue && can_issue;
        retAccept     = readdatavalid && (outstanding_q != '0);
        popAccept     = out_valid && out_ready;
    end

    // Any size pattern that is not exactly one-hot falls back to word.
    always_comb begin
        case ({byte_access, hw, word})
            3'b100:  issueSize = SIZE_BYTE;
            3'b010:  issueSize = SIZE_HALF;
            default: issueSize = SIZE_WORD;
        endcase
    end

    always_comb begin
        headEntry   = offMem_q[offRdPtr_q];
        alignedData = alignData(readdata, headEntry.offset, headEntry.size);
        out_data    = out_valid ? dataMem_q[dataRdPtr_q] : 32'h0;
        proto_err   = protoErr_q;
    end

    // Next-state for pointers and counters. Each counter moves by the net
    // effect of this cycle's push and pop, so simultaneous events cancel.
    always_comb begin
        offWrPtr_d    = offWrPtr_q;
        offRdPtr_d    = offRdPtr_q;
        dataWrPtr_d   = dataWrPtr_q;
        dataRdPtr_d   = dataRdPtr_q;
        outstanding_d = outstanding_q;
        dataCount_d   = dataCount_q;
        protoErr_d    = protoErr_q;

        if (issueAccept) offWrPtr_d  = offWrPtr_q + PTR_W'(1);
        if (retAccept)   offRdPtr_d  = offRdPtr_q + PTR_W'(1);
        if (retAccept)   dataWrPtr_d = dataWrPtr_q + PTR_W'(1);
        if (popAccept)   dataRdPtr_d = dataRdPtr_q + PTR_W'(1);

        if (issueAccept && !retAccept)
            outstanding_d = outstanding_q + CNT_W'(1);
        else if (!issueAccept && retAccept)
            outstanding_d = outstanding_q - CNT_W'(1);

        if (retAccept && !popAccept)
            dataCount_d = dataCount_q + CNT_W'(1);
        else if (!retAccept && popAccept)
            dataCount_d = dataCount_q - CNT_W'(1);

        // Over-issue and orphan returns are both dropped and flagged.
        if ((read_issue && !can_issue) || (readdatavalid && (outstanding_q == '0)))
            protoErr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offWrPtr_q    <= '0;
            offRdPtr_q    <= '0;
            dataWrPtr_q   <= '0;
            dataRdPtr_q   <= '0;
            outstanding_q <= '0;
            dataCount_q   <= '0;
            protoErr_q    <= 1'b0;
        end else begin
            offWrPtr_q    <= offWrPtr_d;
            offRdPtr_q    <= offRdPtr_d;
            dataWrPtr_q   <= dataWrPtr_d;
            dataRdPtr_q   <= dataRdPtr_d;
            outstanding_q <= outstanding_d;
            dataCount_q   <= dataCount_d;
            protoErr_q    <= protoErr_d;
        end
    end

    // Queue storage needs no reset, because the counts gate every read of it.
    always_ff @(posedge clk) begin
        if (issueAccept) begin
            offMem_q[offWrPtr_q] <= '{offset: read_address[1:0], size: issueSize};
        end
        if (retAccept) begin
            dataMem_q[dataWrPtr_q] <= alignedData;
        end
    end

endmodule

// File: tb/tb_soc_design_dma_0_read_aligner.sv
// ---------------------------------------------------------------------------
// Self-checking bench for soc_design_dma_0_read_aligner.
// A reference model tracks the outstanding reads and the expected aligned
// results as plain queues. A negedge monitor compares every DUT output with
// the model and pops expected data when a handshake completes.
// ---------------------------------------------------------------------------
module tb_soc_design_dma_0_read_aligner;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 11;

   localparam logic [2:0] SZ_BYTE = 3'b100;
   localparam logic [2:0] SZ_HALF = 3'b010;
   localparam logic [2:0] SZ_WORD = 3'b001;

   logic              clock;
   logic              reset;
   logic              byteAccess;
   logic              hwAccess;
   logic              wordAccess;
   logic              readIssue;
   logic [ADDR_W-1:0] readAddress;
   logic              readDataValid;
   logic [31:0]       readData;
   logic              canIssue;
   logic              outValid;
   logic              outReady;
   logic [31:0]       outData;
   logic              protoErr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] off;
      int         sz;
   } req_t;

   req_t        pendQ[$];
   logic [31:0] expQ[$];
   bit          modelErr = 0;
   bit          modelCan = 1;

   soc_design_dma_0_read_aligner #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk           (clock),
      .reset         (reset),
      .byte_access   (byteAccess),
      .hw            (hwAccess),
      .word          (wordAccess),
      .read_issue    (readIssue),
      .read_address  (readAddress),
      .readdatavalid (readDataValid),
      .readdata      (readData),
      .can_issue     (canIssue),
      .out_valid     (outValid),
      .out_ready     (outReady),
      .out_data      (outData),
      .proto_err     (protoErr)
   );

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   // The size code is 0 for byte, 1 for halfword and 2 for word. Any pattern
   // that is not one-hot counts as word.
   function automatic int sizeOf(logic [2:0] sz);
      if (sz == SZ_BYTE) return 0;
      if (sz == SZ_HALF) return 1;
      return 2;
   endfunction

   // The expected aligned value is computed from shifts and masks.
   function automatic logic [31:0] refAlign(logic [31:0] d, logic [1:0] off, int sz);
      logic [31:0] b;
      logic [31:0] h;
      b = (d >> (8 * off)) & 32'hFF;
      h = (d >> (16 * (off / 2))) & 32'hFFFF;
      if (sz == 0) begin
`ifdef DMA_READ_REPLICATE_EN
         return b * 32'h01010101;
`else
         return b;
`endif
      end
      if (sz == 1) begin
`ifdef DMA_READ_REPLICATE_EN
         return h * 32'h00010001;
`else
         return h;
`endif
      end
      return d;
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update at the active edge: a return is handled before an issue
   // because the DUT qualifies a return with the outstanding count from
   // before this edge.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         pendQ.delete();
         expQ.delete();
         modelErr = 0;
         modelCan = 1;
      end else begin
         if (readDataValid) begin
            if (pendQ.size() > 0) begin
               req_t r;
               r = pendQ.pop_front();
               expQ.push_back(refAlign(readData, r.off, r.sz));
            end else begin
               modelErr = 1;
            end
         end
         if (readIssue) begin
            if (modelCan) begin
               req_t r;
               r.off = readAddress[1:0];
               r.sz  = sizeOf({byteAccess, hwAccess, wordAccess});
               pendQ.push_back(r);
            end else begin
               modelErr = 1;
            end
         end
      end
   end

   // The monitor samples on the opposite edge and pops on a completed handshake.
   always @(negedge clock) begin
      if (!reset) begin
         modelCan = (pendQ.size() + expQ.size()) < DEPTH;
         checkOutput("can_issue", canIssue, modelCan);
         checkOutput("proto_err", protoErr, modelErr);
         checkOutput("out_valid", outValid, expQ.size() != 0);
         if (outValid && expQ.size() != 0) begin
            checkOutput("out_data", outData, expQ[0]);
            if (outReady) void'(expQ.pop_front());
         end
      end
   end

   task automatic applyStimulus(input bit iss, input logic [ADDR_W-1:0] addr,
                                input logic [2:0] sz, input bit rdv,
                                input logic [31:0] d, input bit rdy);
      @(posedge clock);
      #1;
      readIssue     = iss;
      readAddress   = addr;
      {byteAccess, hwAccess, wordAccess} = sz;
      readDataValid = rdv;
      readData      = d;
      outReady      = rdy;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) applyStimulus(0, '0, SZ_WORD, 0, 32'h0, rdy);
   endtask

   // Return every outstanding read and drain all buffered data, within a bound.
   task automatic drainAll();
      int n;
      n = 0;
      while ((pendQ.size() > 0 || expQ.size() > 0) && n < 100) begin
         @(posedge clock);
         #1;
         readIssue     = 0;
         readDataValid = pendQ.size() > 0;
         readData      = $urandom;
         outReady      = 1;
         n++;
      end
      idle(2, 1);
      checkOutput("drain_empty", (pendQ.size() + expQ.size()), 0);
   endtask

   task automatic pulseReset();
      @(negedge clock);
      #2 reset = 1;
      #10;
      @(negedge clock);
      #2 reset = 0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset         = 1;
      readIssue     = 0;
      readAddress   = '0;
      {byteAccess, hwAccess, wordAccess} = SZ_WORD;
      readDataValid = 0;
      readData      = 0;
      outReady      = 0;
      #12;
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_out_data", outData, 32'h0);
      checkOutput("rst_can_issue", canIssue, 1);
      checkOutput("rst_proto_err", protoErr, 0);
      @(negedge clock);
      #2 reset = 0;

      $display("[TB] byte lanes");
      applyStimulus(1, 11'h101, SZ_BYTE, 0, 0, 1);
      applyStimulus(1, 11'h102, SZ_BYTE, 0, 0, 1);
      applyStimulus(1, 11'h103, SZ_BYTE, 0, 0, 1);
      applyStimulus(1, 11'h100, SZ_BYTE, 0, 0, 1);
      for (int i = 0; i < 4; i++) applyStimulus(0, '0, SZ_BYTE, 1, 32'hA1B2C3D4, 1);
      idle(3, 1);

      $display("[TB] halfword and word");
      applyStimulus(1, 11'h002, SZ_HALF, 0, 0, 1);
      applyStimulus(1, 11'h000, SZ_HALF, 0, 0, 1);
      applyStimulus(1, 11'h004, SZ_WORD, 0, 0, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, '0, SZ_WORD, 1, 32'h12345678, 1);
      idle(3, 1);

      $display("[TB] per-read size capture");
      applyStimulus(1, 11'h001, SZ_BYTE, 0, 0, 1);
      applyStimulus(1, 11'h004, SZ_WORD, 0, 0, 1);
      applyStimulus(0, '0, SZ_WORD, 1, 32'hCAFEF00D, 1);
      applyStimulus(0, '0, SZ_HALF, 1, 32'h0BADBEEF, 1);
      idle(3, 1);

      $display("[TB] simultaneous issue, return and pop");
      applyStimulus(1, 11'h000, SZ_WORD, 0, 0, 1);
      applyStimulus(1, 11'h003, SZ_BYTE, 1, $urandom, 0);
      for (int i = 0; i < 20; i++) begin
         logic [2:0] sz;
         sz = 3'b001 << ($urandom % 3);
         applyStimulus(1, ADDR_W'($urandom), sz, 1, $urandom, 1);
      end
      idle(1, 1);
      drainAll();

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         int sum;
         @(posedge clock);
         #1;
         sum = pendQ.size() + expQ.size();
         readIssue     = ($urandom % 3 != 0) && (sum < DEPTH);
         readAddress   = ADDR_W'($urandom);
         {byteAccess, hwAccess, wordAccess} = 3'($urandom % 8);
         readDataValid = ($urandom % 2 == 1) && (pendQ.size() > 0);
         readData      = $urandom;
         outReady      = ($urandom % 4 != 0);
      end
      drainAll();

      $display("[TB] full queue and over-issue");
      for (int i = 0; i < 4; i++) applyStimulus(1, ADDR_W'(i), SZ_WORD, 0, 0, 0);
      applyStimulus(1, 11'h010, SZ_BYTE, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, '0, SZ_WORD, 1, $urandom, 0);
      idle(2, 0);
      idle(1, 1);
      idle(2, 0);
      drainAll();
      checkOutput("over_issue_err", protoErr, 1);

      pulseReset();
      $display("[TB] orphan return");
      applyStimulus(0, '0, SZ_WORD, 1, 32'hDEADBEEF, 1);
      idle(3, 1);
      checkOutput("orphan_valid", outValid, 0);
      checkOutput("orphan_err", protoErr, 1);

      $display("[TB] asynchronous reset with buffered data");
      for (int i = 0; i < 3; i++) applyStimulus(1, ADDR_W'(i), SZ_BYTE, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, '0, SZ_WORD, 1, 32'h55AA33CC, 0);
      idle(2, 0);
      checkOutput("buffered_valid", outValid, 1);
      @(posedge clock);
      #3 reset = 1;
      #1;
      checkOutput("async_out_valid", outValid, 0);
      checkOutput("async_out_data", outData, 32'h0);
      checkOutput("async_can_issue", canIssue, 1);
      checkOutput("async_proto_err", protoErr, 0);
      @(negedge clock);
      #2 reset = 0;
      idle(3, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
